// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - encodings shared by the multicycle RV32I control path
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic {
    ADR_PC     = 1'b0,
    ADR_ALUOUT = 1'b1
  } adr_src_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_t;

  // Immediate format implied by the opcode; loads and I-type ALU share the I format.
  function automatic imm_src_t imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - maps alu_op/funct3/funct7 to the ALU operation select
module alu_decoder
  import cpu_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALU_OP_ADD: alu_control_o = ALU_ADD;
      ALU_OP_SUB: alu_control_o = ALU_SUB;
      default: begin
        case (funct3_i)
          // IR[30] is part of the immediate for addi, so it only selects sub on R-type
          3'b000:  alu_control_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multicycle RV32I core
module multicycle_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] imm_src_o,
  output logic [2:0] alu_control_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t      state_q, state_d;
  alu_op_t     alu_op;
  adr_src_t    adr_src;
  result_src_t result_src;
  src_a_t      src_a;
  src_b_t      src_b;
  imm_src_t    imm_src;
  logic        pc_write, mem_write, ir_write, reg_write, illegal;
  logic [2:0]  alu_control;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_FETCH;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    adr_src    = ADR_PC;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    imm_src    = IMM_I;
    alu_op     = ALU_OP_ADD;

    case (state_q)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_ready_i;
        pc_write   = mem_ready_i;
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm parks the branch/jump target in ALUOut
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = imm_src_for(op_i);
        case (op_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        imm_src = imm_src_for(op_i);
        state_d = (op_i == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = ADR_ALUOUT;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWRITE: begin
        adr_src   = ADR_ALUOUT;
        mem_write = 1'b1;
        if (mem_ready_i) state_d = S_FETCH;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_R: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_RS2;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALUWB;
      end
      S_EXEC_I: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        imm_src = IMM_I;
        alu_op  = ALU_OP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link address
        src_a      = SRCA_OLDPC;
        src_b      = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        state_d    = S_ALUWB;
      end
      S_BEQ: begin
        src_a      = SRCA_RS1;
        src_b      = SRCB_RS2;
        alu_op     = ALU_OP_SUB;
        result_src = RES_ALUOUT;
        pc_write   = zero_i;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3_i),
    .op5_i         (op_i[5]),
    .funct7b5_i    (funct7b5_i),
    .alu_control_o (alu_control)
  );

  // Reset gates the outputs combinationally so nothing commits on or after the reset edge.
  assign pc_write_o    = reset_ni & pc_write;
  assign mem_write_o   = reset_ni & mem_write;
  assign ir_write_o    = reset_ni & ir_write;
  assign reg_write_o   = reset_ni & reg_write;
  assign illegal_o     = reset_ni & illegal;
  assign adr_src_o     = reset_ni & adr_src;
  assign result_src_o  = reset_ni ? result_src : RES_ALUOUT;
  assign alu_src_a_o   = reset_ni ? src_a : SRCA_PC;
  assign alu_src_b_o   = reset_ni ? src_b : SRCB_RS2;
  assign imm_src_o     = reset_ni ? imm_src : IMM_I;
  assign alu_control_o = reset_ni ? alu_control : 3'b000;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import cpu_ctrl_pkg::*;

  logic       clk_i = 1'b0;
  logic       reset_ni = 1'b0;
  logic [6:0] op_i = OP_R;
  logic [2:0] funct3_i = 3'b000;
  logic       funct7b5_i = 1'b0;
  logic       zero_i = 1'b0;
  logic       mem_ready_i = 1'b1;
  logic       pc_write_o, adr_src_o, mem_write_o, ir_write_o, reg_write_o, illegal_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o;
  logic [2:0] alu_control_o;
  logic [3:0] state_o;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl dut (
    .clk_i         (clk_i),
    .reset_ni      (reset_ni),
    .op_i          (op_i),
    .funct3_i      (funct3_i),
    .funct7b5_i    (funct7b5_i),
    .zero_i        (zero_i),
    .mem_ready_i   (mem_ready_i),
    .pc_write_o    (pc_write_o),
    .adr_src_o     (adr_src_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_write_o   (reg_write_o),
    .result_src_o  (result_src_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .imm_src_o     (imm_src_o),
    .alu_control_o (alu_control_o),
    .illegal_o     (illegal_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    op_i = op;
    funct3_i = f3;
    funct7b5_i = f7;
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clk_i);
    mem_ready_i = rdy;
    #1;
  endtask

  // Expected ALU select from the funct3 table; IR[30] means sub only on R-type.
  function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic rtype, input logic f7);
    case (f3)
      3'b000:  return (rtype && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  task automatic test_reset();
    set_ir(OP_R, 3'b000, 1'b0);
    mem_ready_i = 1'b1;
    @(negedge clk_i); #1;
    checks++;
    if ({state_o, pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_o} !== {S_FETCH, 5'b00000}) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected %b",
               {state_o, pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_o}, {S_FETCH, 5'b00000});
    end
    checks++;
    if ({adr_src_o, result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o} !== 9'b0) begin
      errors++;
      $display("FAIL reset_selects: got %b expected 0",
               {adr_src_o, result_src_o, alu_src_a_o, alu_src_b_o, imm_src_o});
    end
    @(negedge clk_i);
    reset_ni = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if ({state_o, alu_src_b_o, result_src_o, pc_write_o} !== {S_FETCH, 2'b10, 2'b10, 1'b0}) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b",
               {state_o, alu_src_b_o, result_src_o, pc_write_o}, {S_FETCH, 2'b10, 2'b10, 1'b0});
    end
  endtask

  task automatic test_r_type();
    set_ir(OP_R, 3'b000, 1'b0);
    zero_i = 1'b0;
    cyc(1'b1);
    checks++;
    if ({state_o, ir_write_o, pc_write_o, alu_src_b_o, result_src_o} !== {S_FETCH, 1'b1, 1'b1, 2'b10, 2'b10}) begin
      errors++;
      $display("FAIL add_fetch: got %b expected %b",
               {state_o, ir_write_o, pc_write_o, alu_src_b_o, result_src_o}, {S_FETCH, 1'b1, 1'b1, 2'b10, 2'b10});
    end
    cyc(1'b1);
    checks++;
    if ({state_o, alu_src_a_o, alu_src_b_o, alu_control_o} !== {S_DECODE, 2'b01, 2'b01, 3'b000}) begin
      errors++;
      $display("FAIL add_decode: got %b expected %b",
               {state_o, alu_src_a_o, alu_src_b_o, alu_control_o}, {S_DECODE, 2'b01, 2'b01, 3'b000});
    end
    cyc(1'b1);
    checks++;
    if ({state_o, alu_src_a_o, alu_src_b_o, alu_control_o, reg_write_o} !== {S_EXEC_R, 2'b10, 2'b00, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL add_exec: got %b expected %b",
               {state_o, alu_src_a_o, alu_src_b_o, alu_control_o, reg_write_o}, {S_EXEC_R, 2'b10, 2'b00, 3'b000, 1'b0});
    end
    cyc(1'b1);
    checks++;
    if ({state_o, reg_write_o, result_src_o, mem_write_o} !== {S_ALUWB, 1'b1, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL add_wb: got %b expected %b",
               {state_o, reg_write_o, result_src_o, mem_write_o}, {S_ALUWB, 1'b1, 2'b00, 1'b0});
    end
    cyc(1'b0);
    checks++;
    if ({state_o, reg_write_o, pc_write_o} !== {S_FETCH, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL add_return: got %b expected %b", {state_o, reg_write_o, pc_write_o}, {S_FETCH, 1'b0, 1'b0});
    end
  endtask

  task automatic test_sub_addi();
    set_ir(OP_R, 3'b000, 1'b1);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    checks++;
    if ({state_o, alu_control_o} !== {S_EXEC_R, 3'b001}) begin
      errors++;
      $display("FAIL sub_exec: got %b expected %b", {state_o, alu_control_o}, {S_EXEC_R, 3'b001});
    end
    cyc(1'b1); cyc(1'b0);
    set_ir(OP_I, 3'b000, 1'b1);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    checks++;
    if ({state_o, alu_control_o, alu_src_a_o, alu_src_b_o, imm_src_o} !== {S_EXEC_I, 3'b000, 2'b10, 2'b01, 2'b00}) begin
      errors++;
      $display("FAIL addi_exec: got %b expected %b",
               {state_o, alu_control_o, alu_src_a_o, alu_src_b_o, imm_src_o}, {S_EXEC_I, 3'b000, 2'b10, 2'b01, 2'b00});
    end
    cyc(1'b1);
    checks++;
    if ({state_o, reg_write_o} !== {S_ALUWB, 1'b1}) begin
      errors++;
      $display("FAIL addi_wb: got %b expected %b", {state_o, reg_write_o}, {S_ALUWB, 1'b1});
    end
    cyc(1'b0);
  endtask

  task automatic test_lw_stall();
    int  ncyc = 0;
    int  nrw = 0;
    int  nmw = 0;
    int  stalls = 0;
    int  bad_src = 0;
    bit  back = 0;
    set_ir(OP_LW, 3'b010, 1'b0);
    for (int i = 0; i < 20 && !back; i++) begin
      @(negedge clk_i);
      if (state_o == S_MEMREAD && stalls < 3) begin
        mem_ready_i = 1'b0;
        stalls++;
      end else begin
        mem_ready_i = 1'b1;
      end
      #1;
      if (i > 0 && state_o == S_FETCH) begin
        back = 1;
        mem_ready_i = 1'b0;
      end else begin
        ncyc++;
        nrw += int'(reg_write_o);
        nmw += int'(mem_write_o);
        if (reg_write_o && result_src_o !== 2'b01) bad_src++;
      end
    end
    checks++;
    if (!back || ncyc != 8) begin
      errors++;
      $display("FAIL lw_cycles: got %0d (returned=%0d) expected 8", ncyc, back);
    end
    checks++;
    if (nrw != 1 || nmw != 0 || bad_src != 0) begin
      errors++;
      $display("FAIL lw_writes: got reg_write=%0d mem_write=%0d bad_result_src=%0d expected 1 0 0", nrw, nmw, bad_src);
    end
  endtask

  task automatic test_beq();
    for (int z = 1; z >= 0; z--) begin
      set_ir(OP_BEQ, 3'b000, 1'b0);
      zero_i = 1'b0;
      cyc(1'b1);
      cyc(1'b1);
      checks++;
      if ({state_o, imm_src_o} !== {S_DECODE, 2'b10}) begin
        errors++;
        $display("FAIL beq_decode: got %b expected %b", {state_o, imm_src_o}, {S_DECODE, 2'b10});
      end
      zero_i = z[0];
      cyc(1'b1);
      checks++;
      if ({state_o, pc_write_o, alu_control_o, alu_src_a_o, alu_src_b_o} !== {S_BEQ, z[0], 3'b001, 2'b10, 2'b00}) begin
        errors++;
        $display("FAIL beq_exec zero=%0d: got %b expected %b", z,
                 {state_o, pc_write_o, alu_control_o, alu_src_a_o, alu_src_b_o}, {S_BEQ, z[0], 3'b001, 2'b10, 2'b00});
      end
      cyc(1'b0);
      checks++;
      if ({state_o, pc_write_o} !== {S_FETCH, 1'b0}) begin
        errors++;
        $display("FAIL beq_return zero=%0d: got %b expected %b", z, {state_o, pc_write_o}, {S_FETCH, 1'b0});
      end
    end
  endtask

  task automatic test_illegal();
    set_ir(7'b1111111, 3'b000, 1'b0);
    cyc(1'b1);
    cyc(1'b1);
    checks++;
    if ({state_o, illegal_o, reg_write_o, mem_write_o, pc_write_o, ir_write_o} !== {S_DECODE, 5'b10000}) begin
      errors++;
      $display("FAIL illegal_decode: got %b expected %b",
               {state_o, illegal_o, reg_write_o, mem_write_o, pc_write_o, ir_write_o}, {S_DECODE, 5'b10000});
    end
    cyc(1'b0);
    checks++;
    if ({state_o, illegal_o} !== {S_FETCH, 1'b0}) begin
      errors++;
      $display("FAIL illegal_next: got %b expected %b", {state_o, illegal_o}, {S_FETCH, 1'b0});
    end
  endtask

  task automatic test_reset_mid_write();
    set_ir(OP_SW, 3'b010, 1'b0);
    cyc(1'b1); cyc(1'b1); cyc(1'b1); cyc(1'b0);
    checks++;
    if ({state_o, mem_write_o, adr_src_o} !== {S_MEMWRITE, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sw_hold: got %b expected %b", {state_o, mem_write_o, adr_src_o}, {S_MEMWRITE, 1'b1, 1'b1});
    end
    #1 reset_ni = 1'b0;
    #1;
    checks++;
    if ({state_o, mem_write_o} !== {S_FETCH, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_write: got %b expected %b", {state_o, mem_write_o}, {S_FETCH, 1'b0});
    end
    @(negedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if ({state_o, mem_write_o, reg_write_o} !== {S_FETCH, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_release: got %b expected %b", {state_o, mem_write_o, reg_write_o}, {S_FETCH, 1'b0, 1'b0});
    end
  endtask

  // Each instruction class is an ordered list of phases; FETCH and the memory
  // access phases repeat while memory is not ready.
  task automatic test_random();
    logic [6:0] bad_ops [4] = '{7'b1111111, 7'b0110111, 7'b0000000, 7'b1100111};
    logic [2:0] alu_f3  [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    state_t     phases[$];
    state_t     exp_st;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, rdy, zero, bad;
    logic [4:0] exp_strb;
    int         kind, idx, guard;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 6);
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      bad = 1'b0;
      phases.delete();
      phases.push_back(S_FETCH);
      phases.push_back(S_DECODE);
      case (kind)
        0: begin op = OP_LW; phases.push_back(S_MEMADR); phases.push_back(S_MEMREAD); phases.push_back(S_MEMWB); end
        1: begin op = OP_SW; phases.push_back(S_MEMADR); phases.push_back(S_MEMWRITE); end
        2: begin op = OP_R; f3 = alu_f3[$urandom_range(0, 3)]; phases.push_back(S_EXEC_R); phases.push_back(S_ALUWB); end
        3: begin op = OP_I; f3 = alu_f3[$urandom_range(0, 3)]; phases.push_back(S_EXEC_I); phases.push_back(S_ALUWB); end
        4: begin op = OP_JAL; phases.push_back(S_JAL); phases.push_back(S_ALUWB); end
        5: begin op = OP_BEQ; phases.push_back(S_BEQ); end
        default: begin op = bad_ops[$urandom_range(0, 3)]; bad = 1'b1; end
      endcase
      idx = 0;
      guard = 0;
      while (idx < phases.size() && guard < 60) begin
        @(negedge clk_i);
        if (guard == 0) set_ir(op, f3, f7);
        rdy = ($urandom_range(0, 3) != 0);
        zero = 1'($urandom_range(0, 1));
        mem_ready_i = rdy;
        zero_i = zero;
        #1;
        exp_st = phases[idx];
        checks++;
        if (state_o !== exp_st) begin
          errors++;
          $display("FAIL rand_state n=%0d: got %0d expected %0d", n, state_o, exp_st);
        end
        exp_strb[4] = (exp_st == S_FETCH && rdy) || exp_st == S_JAL || (exp_st == S_BEQ && zero);
        exp_strb[3] = (exp_st == S_FETCH && rdy);
        exp_strb[2] = (exp_st == S_MEMWRITE);
        exp_strb[1] = (exp_st == S_MEMWB || exp_st == S_ALUWB);
        exp_strb[0] = (exp_st == S_DECODE && bad);
        checks++;
        if ({pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_o} !== exp_strb) begin
          errors++;
          $display("FAIL rand_strobes n=%0d state=%0d: got %b expected %b", n, exp_st,
                   {pc_write_o, ir_write_o, mem_write_o, reg_write_o, illegal_o}, exp_strb);
        end
        if (exp_st == S_EXEC_R || exp_st == S_EXEC_I) begin
          checks++;
          if (alu_control_o !== exp_alu(f3, exp_st == S_EXEC_R, f7)) begin
            errors++;
            $display("FAIL rand_alu n=%0d f3=%b f7=%b: got %b expected %b", n, f3, f7,
                     alu_control_o, exp_alu(f3, exp_st == S_EXEC_R, f7));
          end
        end
        if (!((exp_st == S_FETCH || exp_st == S_MEMREAD || exp_st == S_MEMWRITE) && !rdy)) idx++;
        guard++;
      end
      checks++;
      if (idx != phases.size()) begin
        errors++;
        $display("FAIL rand_timeout n=%0d: reached phase %0d of %0d", n, idx, phases.size());
      end
    end
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1;
    checks++;
    if (state_o !== S_FETCH) begin
      errors++;
      $display("FAIL rand_park: got %0d expected %0d", state_o, S_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_sub_addi();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
